fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage and IF/ID pipeline register of the pipelined RV32I core.
//   Holds the program counter and drives the instruction-memory request.
//   Registers the fetched instruction, its PC and PC+4 into the IF/ID register.
//   Downstream, instr_d[6:0] feeds the main decoder's op input; the decoder's PCSrc,
//   resolved in EX, returns here as pc_src_e.
// PARAMETERS
//   XLEN     32            address/PC width in bits
//   RESET_PC 32'h0000_0000 PC value loaded on reset
//   NOP      32'h0000_0013 bubble instruction (addi x0,x0,0) inserted on flush/miss
// PORTS
//   clk          in   1     rising-edge clock
//   rst_n        in   1     asynchronous, active-low reset
//   stall_f      in   1     hazard unit: hold PC
//   stall_d      in   1     hazard unit: hold IF/ID register
//   flush_d      in   1     hazard unit: replace IF/ID contents with bubble
//   pc_src_e     in   1     taken branch/jump resolved in EX (zero & branch)
//   pc_target_e  in   XLEN  redirect target from EX
//   imem_req     out  1     fetch request valid this cycle
//   imem_addr    out  XLEN  fetch address (= PC_F)
//   imem_rdata   in   32    instruction word, valid when imem_ready=1
//   imem_ready   in   1     memory returns imem_rdata this cycle (same-cycle read)
//   instr_d      out  32    IF/ID instruction
//   pc_d         out  XLEN  IF/ID PC of instr_d
//   pc_plus4_d   out  XLEN  IF/ID PC+4 of instr_d
//   valid_d      out  1     1 = instr_d is a real instruction, 0 = bubble
// BEHAVIOUR
//   Reset (rst_n=0, async):
//     PC_F=RESET_PC; instr_d=NOP; pc_d=0; pc_plus4_d=0; valid_d=0.
//     imem_req=0 while rst_n=0.
//   Combinational outputs:
//     imem_addr = PC_F.
//     imem_req  = rst_n & ~stall_f & ~pc_src_e.
//   PC update at posedge, priority high->low:
//     1 pc_src_e=1  : PC_F <= {pc_target_e[XLEN-1:2],2'b00}. Overrides stall_f.
//     2 stall_f=1   : PC_F holds.
//     3 imem_ready=0: PC_F holds (retry same address next cycle).
//     4 otherwise   : PC_F <= PC_F + 4, modulo 2^XLEN (wraps to 0 past 32'hFFFF_FFFC).
//   IF/ID update at posedge, priority high->low:
//     1 flush_d=1 or pc_src_e=1: instr_d<=NOP, valid_d<=0; pc_d, pc_plus4_d <= 0.
//     2 stall_d=1  : all IF/ID outputs hold (valid_d included).
//     3 stall_f=1 or imem_ready=0: bubble as in 1.
//     4 otherwise  : instr_d<=imem_rdata, pc_d<=PC_F, pc_plus4_d<=PC_F+4, valid_d<=1.
//   Latency: instruction at PC_F appears on instr_d 1 cycle after the imem_ready=1 edge.
//   Branch penalty: the IF/ID entry fetched in the redirect cycle is squashed;
//     the target instruction reaches instr_d 2 edges after pc_src_e is sampled.
//   Simultaneous events:
//     stall_d & flush_d -> flush wins.
//     stall_f & pc_src_e -> redirect wins.
//     stall_d & ~stall_f -> legal; the PC advances and the fetched word is dropped.
//       The hazard unit never issues this combination.
//   Reset mid-operation: all state returns to reset values immediately (async).
//     First fetch at RESET_PC on the first edge after rst_n rises.
//   imem_rdata is ignored whenever imem_ready=0; X on imem_rdata must not reach instr_d.
// TESTING
//   1 Reset release, imem_ready=1, sequential words -> imem_addr 0,4,8;
//     instr_d = word@0 one edge later; valid_d=1; pc_plus4_d=4.
//   2 stall_f=stall_d=1 for 3 cycles at PC=8 -> PC_F stays 8, IF/ID holds;
//     resumes at 12 after release.
//   3 pc_src_e=1, pc_target_e=32'h100 while stall_f=1 -> PC_F=0x100 next edge;
//     instr_d=NOP, valid_d=0; word@0x100 on instr_d one edge later.
//   4 imem_ready=0 for 2 cycles at PC=0x20 -> PC_F holds 0x20; two bubbles (valid_d=0);
//     then instr_d = word@0x20.
//   5 PC_F=32'hFFFF_FFFC, imem_ready=1 -> PC_F wraps to 0; pc_plus4_d=0.
//   6 Assert rst_n=0 mid-stream with a valid IF/ID entry -> outputs reset asynchronously
//     (valid_d=0, PC_F=RESET_PC) without waiting for clk.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the pipelined RV32I core: owns PC_F, issues the
// instruction-memory request and registers instruction, PC and PC+4 into IF/ID.
module fetch_stage #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = '0,
  parameter logic [31:0]       NOP      = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_f,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic            pc_src_e,
  input  logic [XLEN-1:0] pc_target_e,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ready,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d
);

  logic [XLEN-1:0] pc_p0;
  logic [XLEN-1:0] pc_plus4_p0;
  logic [XLEN-1:0] pc_next_p0;
  logic            fetch_ok_p0;

  assign pc_plus4_p0 = pc_p0 + XLEN'(4);
  assign imem_addr   = pc_p0;
  assign imem_req    = rst_n & ~stall_f & ~pc_src_e;
  assign fetch_ok_p0 = ~stall_f & imem_ready;

  // Redirect beats stall; a miss retries the same address.
  always_comb begin
    pc_next_p0 = pc_p0;
    if (pc_src_e)
      pc_next_p0 = {pc_target_e[XLEN-1:2], 2'b00};
    else if (fetch_ok_p0)
      pc_next_p0 = pc_plus4_p0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc_p0 <= RESET_PC;
    else
      pc_p0 <= pc_next_p0;
  end

  // ---- IF/ID boundary ----
  // imem_rdata is only captured on a real fetch, so X during a miss never lands here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_d    <= NOP;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (flush_d || pc_src_e) begin
      instr_d    <= NOP;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (stall_d) begin
      instr_d    <= instr_d;
      pc_d       <= pc_d;
      pc_plus4_d <= pc_plus4_d;
      valid_d    <= valid_d;
    end else if (!fetch_ok_p0) begin
      instr_d    <= NOP;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else begin
      instr_d    <= imem_rdata;
      pc_d       <= pc_p0;
      pc_plus4_d <= pc_plus4_p0;
      valid_d    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized hazard traffic,
// compared against a cycle-level model of the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_f, stall_d, flush_d, pc_src_e;
  logic [31:0] pc_target_e;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic        valid_d;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4d;
  logic        m_vld;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .instr_d(instr_d), .pc_d(pc_d),
    .pc_plus4_d(pc_plus4_d), .valid_d(valid_d)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a ^ 32'hDEAD_0000) + 32'h0000_0003;
  endfunction

  always_comb begin
    imem_rdata = 32'hx;
    if (imem_ready) imem_rdata = word_at(imem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP; m_pcd = 32'h0; m_pc4d = 32'h0; m_vld = 1'b0;
  endtask

  task automatic check_ifid(input string tag);
    chk({tag, ".instr_d"},    instr_d,    m_instr);
    chk({tag, ".pc_d"},       pc_d,       m_pcd);
    chk({tag, ".pc_plus4_d"}, pc_plus4_d, m_pc4d);
    chk({tag, ".valid_d"},    {31'b0, valid_d}, {31'b0, m_vld});
    chk({tag, ".imem_addr"},  imem_addr,  m_pc);
  endtask

  // One clock: drive inputs, check request side, clock, advance model, check IF/ID.
  task automatic step(input string tag, input logic sf, input logic sd, input logic fd,
                      input logic br, input logic [31:0] tgt, input logic rdy);
    logic [31:0] n_pc;
    logic        fetched;
    stall_f = sf; stall_d = sd; flush_d = fd; pc_src_e = br;
    pc_target_e = tgt; imem_ready = rdy;
    #1;
    chk({tag, ".req"},  {31'b0, imem_req}, {31'b0, (!sf && !br)});
    chk({tag, ".addr"}, imem_addr, m_pc);
    fetched = !sf && rdy;
    if (br)           n_pc = tgt & 32'hFFFF_FFFC;
    else if (fetched) n_pc = m_pc + 32'd4;
    else              n_pc = m_pc;
    if (fd || br || (!sd && !fetched)) begin
      m_instr = NOP; m_pcd = 32'h0; m_pc4d = 32'h0; m_vld = 1'b0;
    end else if (!sd) begin
      m_instr = word_at(m_pc); m_pcd = m_pc; m_pc4d = m_pc + 32'd4; m_vld = 1'b1;
    end
    m_pc = n_pc;
    @(posedge clk);
    #1;
    check_ifid(tag);
  endtask

  initial begin
    rst_n = 1'b0; stall_f = 0; stall_d = 0; flush_d = 0; pc_src_e = 0;
    pc_target_e = 0; imem_ready = 0;
    model_reset();
    #12;
    check_ifid("reset");
    chk("reset.req", {31'b0, imem_req}, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // Sequential fetch from reset
    for (int i = 0; i < 3; i++) step("seq", 0, 0, 0, 0, 0, 1);

    // Full stall at PC=8 style hold, then resume
    model_reset();
    rst_n = 1'b0; #1; @(negedge clk) rst_n = 1'b1;
    step("seq2", 0, 0, 0, 0, 0, 1);
    step("seq2", 0, 0, 0, 0, 0, 1);
    chk("stall.pc_at_8", imem_addr, 32'h8);
    for (int i = 0; i < 3; i++) step("stall", 1, 1, 0, 0, 0, 1);
    step("resume", 0, 0, 0, 0, 0, 1);
    chk("resume.pc_12", pc_d, 32'h8);
    step("resume", 0, 0, 0, 0, 0, 1);

    // Redirect while stalled
    step("redir", 1, 0, 0, 1, 32'h0000_0100, 1);
    chk("redir.pc", imem_addr, 32'h100);
    step("redir_tgt", 0, 0, 0, 0, 0, 1);
    chk("redir.word", instr_d, word_at(32'h100));

    // Memory misses at 0x20 (unaligned target bits dropped)
    step("to20", 0, 0, 0, 1, 32'h0000_0023, 1);
    step("miss", 0, 0, 0, 0, 0, 0);
    step("miss", 0, 0, 0, 0, 0, 0);
    step("hit20", 0, 0, 0, 0, 0, 1);
    chk("miss.word20", instr_d, word_at(32'h20));

    // Flush beats stall_d
    step("flush", 1, 1, 1, 0, 0, 1);

    // PC wrap
    step("toFFC", 0, 0, 0, 1, 32'hFFFF_FFFC, 1);
    step("wrap", 0, 0, 0, 0, 0, 1);
    chk("wrap.pc", imem_addr, 32'h0);
    chk("wrap.pc4", pc_plus4_d, 32'h0);

    // Randomized hazard traffic
    for (int i = 0; i < 400; i++) begin
      logic sf, sd, fd, br, rdy;
      sf  = ($urandom_range(0, 4) == 0);
      sd  = sf && ($urandom_range(0, 1) == 0);
      fd  = ($urandom_range(0, 9) == 0);
      br  = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      step("rand", sf, sd, fd, br, $urandom, rdy);
    end

    // Async reset mid-stream with a valid entry
    step("pre_rst", 0, 0, 0, 0, 0, 1);
    chk("pre_rst.valid", {31'b0, valid_d}, 32'h1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_ifid("async_rst");
    chk("async_rst.req", {31'b0, imem_req}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    step("post_rst", 0, 0, 0, 0, 0, 1);
    chk("post_rst.word0", instr_d, word_at(32'h0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
